// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and helpers for the registered 5-bit signed ALU.
package alu_pkg;

    localparam int OP_W   = 5;   // operand width
    localparam int RES_W  = 6;   // result width (one guard bit)
    localparam int A_OP_W = 3;   // set A opcode width
    localparam int B_OP_W = 2;   // set B / set AB opcode width

    // Set A opcodes (a_en=1, b_en=0). The two AND encodings are intentional aliases.
    typedef enum logic [A_OP_W-1:0] {
        A_ADD  = 3'd0,
        A_SUB  = 3'd1,
        A_XOR  = 3'd2,
        A_AND0 = 3'd3,
        A_AND1 = 3'd4,
        A_OR   = 3'd5,
        A_XNOR = 3'd6,
        A_NULL = 3'd7
    } a_op_e;

    // Set B opcodes (a_en=0, b_en=1). The two ADD encodings are intentional aliases.
    typedef enum logic [B_OP_W-1:0] {
        B_NAND = 2'd0,
        B_ADD0 = 2'd1,
        B_ADD1 = 2'd2,
        B_NULL = 2'd3
    } b_op_e;

    // Set AB opcodes (a_en=1, b_en=1), selected by b_op.
    typedef enum logic [B_OP_W-1:0] {
        AB_XOR    = 2'd0,
        AB_XNOR   = 2'd1,
        AB_DEC_A  = 2'd2,
        AB_INC2_B = 2'd3
    } ab_op_e;

    // Sign-extend an operand to result width; every operation, logic included,
    // works on the extended value so the guard bit is well defined.
    function automatic logic signed [RES_W-1:0] sext(input logic signed [OP_W-1:0] v);
        return {v[OP_W-1], v};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational operation decode and datapath. Produces the next result and
// whether the output register should take it (load=0 means hold).
module alu_core
    import alu_pkg::*;
(
    input  logic signed [RES_W-1:0]  a,
    input  logic signed [RES_W-1:0]  b,
    input  logic                     a_en,
    input  logic                     b_en,
    input  logic        [A_OP_W-1:0] a_op,
    input  logic        [B_OP_W-1:0] b_op,
    output logic signed [RES_W-1:0]  result,
    output logic                     load
);

    logic signed [RES_W-1:0] res_a;
    logic signed [RES_W-1:0] res_b;
    logic signed [RES_W-1:0] res_ab;

    // Set A result, selected by a_op.
    always_comb begin
        res_a = '0;
        case (a_op_e'(a_op))
            A_ADD:  res_a = a + b;
            A_SUB:  res_a = a - b;
            A_XOR:  res_a = a ^ b;
            A_AND0: res_a = a & b;
            A_AND1: res_a = a & b;
            A_OR:   res_a = a | b;
            A_XNOR: res_a = ~(a ^ b);
            A_NULL: res_a = '0;
            default: res_a = '0;
        endcase
    end

    // Set B result, selected by b_op.
    always_comb begin
        res_b = '0;
        case (b_op_e'(b_op))
            B_NAND: res_b = ~(a & b);
            B_ADD0: res_b = a + b;
            B_ADD1: res_b = a + b;
            B_NULL: res_b = '0;
            default: res_b = '0;
        endcase
    end

    // Set AB result, also selected by b_op.
    always_comb begin
        res_ab = '0;
        case (ab_op_e'(b_op))
            AB_XOR:    res_ab = a ^ b;
            AB_XNOR:   res_ab = ~(a ^ b);
            AB_DEC_A:  res_ab = a - 6'sd1;
            AB_INC2_B: res_ab = b + 6'sd2;
            default:   res_ab = '0;
        endcase
    end

    // Pick the active set; with neither enable set the register holds.
    always_comb begin
        result = '0;
        load   = 1'b0;
        case ({a_en, b_en})
            2'b10: begin
                result = res_a;
                load   = 1'b1;
            end
            2'b01: begin
                result = res_b;
                load   = 1'b1;
            end
            2'b11: begin
                result = res_ab;
                load   = 1'b1;
            end
            default: begin
                result = '0;
                load   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 5-bit signed ALU. Only state is the C register; C comes straight
// from the flop, results appear one clock after the inputs are sampled.
module alu
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ALU_en,
    input  logic                     a_en,
    input  logic                     b_en,
    input  logic        [A_OP_W-1:0] a_op,
    input  logic        [B_OP_W-1:0] b_op,
    input  logic signed [OP_W-1:0]   A,
    input  logic signed [OP_W-1:0]   B,
    output logic signed [RES_W-1:0]  C
);

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] result;
    logic                    load;

    assign a_ext = sext(A);
    assign b_ext = sext(B);

    alu_core u_core (
        .a      (a_ext),
        .b      (b_ext),
        .a_en   (a_en),
        .b_en   (b_en),
        .a_op   (a_op),
        .b_op   (b_op),
        .result (result),
        .load   (load)
    );

    // Result register: reset wins, otherwise load only when enabled and a set is selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            C <= '0;
        end else if (ALU_en && load) begin
            C <= result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer reference model plus literal spot checks.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ALU_en;
    logic       a_en;
    logic       b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
    logic [4:0] A;
    logic [4:0] B;
    logic [5:0] C;

    int n_checks = 0;
    int n_fails  = 0;

    logic [5:0] exp_c;
    logic       model_valid = 1'b0;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ALU_en (ALU_en),
        .a_en   (a_en),
        .b_en   (b_en),
        .a_op   (a_op),
        .b_op   (b_op),
        .A      (A),
        .B      (B),
        .C      (C)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the signed operand values, wrapped to 6 bits.
    function automatic logic [5:0] model_next(input logic [5:0] cur, input logic rn,
                                              input logic en, input logic ae, input logic be,
                                              input logic [2:0] aop, input logic [1:0] bop,
                                              input logic [4:0] av, input logic [4:0] bv);
        int a;
        int b;
        int r;
        if (!rn) return 6'd0;
        if (!en || (!ae && !be)) return cur;
        a = int'($signed(av));
        b = int'($signed(bv));
        r = 0;
        if (ae && !be) begin
            case (aop)
                3'd0: r = a + b;
                3'd1: r = a - b;
                3'd2: r = a ^ b;
                3'd3: r = a & b;
                3'd4: r = a & b;
                3'd5: r = a | b;
                3'd6: r = ~(a ^ b);
                default: r = 0;
            endcase
        end else if (!ae && be) begin
            case (bop)
                2'd0: r = ~(a & b);
                2'd1: r = a + b;
                2'd2: r = a + b;
                default: r = 0;
            endcase
        end else begin
            case (bop)
                2'd0: r = a ^ b;
                2'd1: r = ~(a ^ b);
                2'd2: r = a - 1;
                default: r = b + 2;
            endcase
        end
        return r[5:0];
    endfunction

    // Advance the model on every rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        exp_c <= model_next(exp_c, rst_n, ALU_en, a_en, b_en, a_op, b_op, A, B);
        if (!rst_n) model_valid <= 1'b1;
    end

    // Compare DUT against the model on every falling edge once the model is seeded.
    always @(negedge clk) begin
        if (model_valid) begin
            n_checks++;
            if (C !== exp_c) begin
                n_fails++;
                $display("FAIL model_cmp t=%0t C=%0d expected=%0d", $time, $signed(C), $signed(exp_c));
            end
        end
    end

    task automatic check_lit(input string name, input logic [5:0] want);
        n_checks++;
        if (C !== want) begin
            n_fails++;
            $display("FAIL %s C=%0d expected=%0d", name, $signed(C), $signed(want));
        end
        n_checks++;
        if (exp_c !== want) begin
            n_fails++;
            $display("FAIL model_%s model=%0d expected=%0d", name, $signed(exp_c), $signed(want));
        end
    endtask

    task automatic set_in(input logic en, input logic ae, input logic be,
                          input logic [2:0] aop, input logic [1:0] bop,
                          input logic [4:0] av, input logic [4:0] bv);
        ALU_en = en; a_en = ae; b_en = be; a_op = aop; b_op = bop; A = av; B = bv;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 5'd3);
        cycle();
        cycle();
        check_lit("reset", 6'd0);
        rst_n = 1'b1;
        cycle();
        check_lit("reset_release_add", 6'd10);

        set_in(1'b1, 1'b1, 1'b0, 3'd1, 2'd0, 5'b10000, 5'd15);
        cycle();
        check_lit("sub_extreme", 6'b100001);
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd15, 5'd15);
        cycle();
        check_lit("add_extreme", 6'd30);
        set_in(1'b1, 1'b1, 1'b0, 3'd7, 2'd0, 5'd15, 5'd15);
        cycle();
        check_lit("a_null", 6'd0);

        set_in(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'b10101, 5'b01111);
        cycle();
        check_lit("b_nand", 6'b111010);
        set_in(1'b1, 1'b0, 1'b1, 3'd0, 2'd3, 5'b10101, 5'b01111);
        cycle();
        check_lit("b_null", 6'd0);

        set_in(1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 5'b10000, 5'd0);
        cycle();
        check_lit("ab_dec_a", 6'b101111);
        set_in(1'b1, 1'b1, 1'b1, 3'd0, 2'd3, 5'd0, 5'd15);
        cycle();
        check_lit("ab_inc2_b", 6'd17);
        set_in(1'b1, 1'b1, 1'b1, 3'd0, 2'd0, 5'd5, 5'd3);
        cycle();
        check_lit("ab_xor", 6'd6);

        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 5'd3);
        cycle();
        check_lit("hold_setup", 6'd10);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
                   5'($urandom), 5'($urandom));
            cycle();
            check_lit("hold_alu_en0", 6'd10);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
            cycle();
            check_lit("hold_no_set", 6'd10);
        end

        // All 16 legal set/opcode combinations back to back.
        for (int i = 0; i < 16; i++) begin
            if (i < 8)
                set_in(1'b1, 1'b1, 1'b0, 3'(i), 2'($urandom), 5'($urandom), 5'($urandom));
            else if (i < 12)
                set_in(1'b1, 1'b0, 1'b1, 3'($urandom), 2'(i - 8), 5'($urandom), 5'($urandom));
            else
                set_in(1'b1, 1'b1, 1'b1, 3'($urandom), 2'(i - 12), 5'($urandom), 5'($urandom));
            cycle();
        end

        // Fully random traffic, including occasional mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 15) != 0);
            set_in(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 3'($urandom),
                   2'($urandom), 5'($urandom), 5'($urandom));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
